// File: rtl/tnn_neuron_accum.sv
// tnn_neuron_accum: ternary-weight neuron accumulator.
// Each accepted beat adds (pc_pos - pc_neg) to a signed accumulator.
// A neuron closes on a beat marked in_last, or when it reaches MAX_BEATS beats.
// The closing beat latches the sum, the activation and a truncation flag,
// and these stay presented until the consumer takes them.
// Optional build macro TNN_ACC_SAT_EN: when defined the accumulator saturates;
// when undefined it wraps (two's complement).
module tnn_neuron_accum #(
  parameter int ACC_W     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       pc_pos,
  input  logic [4:0]       pc_neg,
  input  logic             in_last,
  input  logic [ACC_W-1:0] thr_hi,
  input  logic [ACC_W-1:0] thr_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_act,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_trunc
);

  localparam int EXT_W = ACC_W + 2;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic signed [ACC_W-1:0]   acc;
  logic        [CNT_W-1:0]   count;
  logic        [CNT_W-1:0]   count_nxt;
  logic                      beat;
  logic                      close_cnt;
  logic                      close_beat;
  logic signed [EXT_W-1:0]   sum_ext;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic        [1:0]         act_nxt;

  // Handshake flags come straight from the state register, never from out_ready.
  assign in_ready   = (state != HOLD);
  assign out_valid  = (state == HOLD);
  assign beat       = in_valid & in_ready;
  assign count_nxt  = count + CNT_W'(1);
  assign close_cnt  = (count_nxt == CNT_W'(MAX_BEATS));
  assign close_beat = beat & (in_last | close_cnt);

  // Beat arithmetic at two guard bits, then reduced back to ACC_W.
  always_comb begin
    sum_ext = $signed({{2{acc[ACC_W-1]}}, acc})
            + $signed({{(EXT_W-5){1'b0}}, pc_pos})
            - $signed({{(EXT_W-5){1'b0}}, pc_neg});
  end

`ifdef TNN_ACC_SAT_EN
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  // Clamp the widened sum to the representable ACC_W range.
  always_comb begin
    acc_nxt = sum_ext[ACC_W-1:0];
    if (sum_ext > SAT_MAX) begin
      acc_nxt = SAT_MAX[ACC_W-1:0];
    end else if (sum_ext < SAT_MIN) begin
      acc_nxt = SAT_MIN[ACC_W-1:0];
    end
  end
`else
  logic unused_ext_hi;

  // Wrap by dropping the guard bits.
  always_comb begin
    acc_nxt       = sum_ext[ACC_W-1:0];
    unused_ext_hi = ^sum_ext[EXT_W-1:ACC_W];
  end
`endif

  // Ternary activation of the updated sum against the current thresholds.
  always_comb begin
    act_nxt = 2'b00;
    if (acc_nxt >= $signed(thr_hi)) begin
      act_nxt = 2'b01;
    end else if (acc_nxt <= $signed(thr_lo)) begin
      act_nxt = 2'b11;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (beat) begin
          state_nxt = close_beat ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (close_beat) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, beat counter and latched result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      out_act   <= 2'b00;
      out_sum   <= '0;
      out_trunc <= 1'b0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        acc   <= '0;
        count <= '0;
      end
    end else if (beat) begin
      acc   <= acc_nxt;
      count <= count_nxt;
      if (close_beat) begin
        out_sum   <= acc_nxt;
        out_act   <= act_nxt;
        out_trunc <= ~in_last;
      end
    end
  end

endmodule

// File: tb/tb_tnn_neuron_accum.sv
// Testbench for tnn_neuron_accum: directed neurons, expected results queued
// by the stimulus and checked by an independent output monitor.
module tb_tnn_neuron_accum;

  localparam int ACC_W     = 8;
  localparam int MAX_BEATS = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       pc_pos;
  logic [4:0]       pc_neg;
  logic             in_last;
  logic [ACC_W-1:0] thr_hi;
  logic [ACC_W-1:0] thr_lo;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_act;
  logic [ACC_W-1:0] out_sum;
  logic             out_trunc;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [1:0]       act;
    logic             trunc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  tnn_neuron_accum #(
    .ACC_W     (ACC_W),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc_pos    (pc_pos),
    .pc_neg    (pc_neg),
    .in_last   (in_last),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_act   (out_act),
    .out_sum   (out_sum),
    .out_trunc (out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
    end
  endtask

  task automatic push_exp(input int sum, input logic [1:0] act, input logic trunc);
    exp_t e;
    e.sum   = ACC_W'(sum);
    e.act   = act;
    e.trunc = trunc;
    exp_q.push_back(e);
  endtask

  // Present one beat, wait (bounded) until it is taken, then check whether
  // the result appears exactly one cycle later.
  task automatic send_beat(input int p, input int n, input logic last, input logic closes);
    int waited;
    in_valid = 1'b1;
    pc_pos   = 5'(p);
    pc_neg   = 5'(n);
    in_last  = last;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("beat_accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("out_valid_after_beat", int'(out_valid), int'(closes));
  endtask

  // Monitor: compare every delivered result against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sum", int'(out_sum), int'(e.sum));
        chk("out_act", int'(out_act), int'(e.act));
        chk("out_trunc", int'(out_trunc), int'(e.trunc));
      end
    end
  end

  initial begin
    int expected_trunc_sum;
    int drain;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    pc_pos      = '0;
    pc_neg      = '0;
    in_last     = 1'b0;
    thr_hi      = 8'sd10;
    thr_lo      = -8'sd10;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_sum", int'(out_sum), 0);
    chk("reset_out_act", int'(out_act), 0);
    chk("reset_out_trunc", int'(out_trunc), 0);
    @(posedge clk);
    #1;

    // Three beats, closed by in_last: 20 + 20 + 2 = 42.
    thr_hi = 8'sd10;
    thr_lo = -8'sd10;
    push_exp(42, 2'b01, 1'b0);
    send_beat(20, 0, 1'b0, 1'b0);
    send_beat(20, 0, 1'b0, 1'b0);
    send_beat(5, 3, 1'b1, 1'b1);
    @(posedge clk);
    #1;

    // Single-beat neuron: 2 - 9 = -7 straight to the result.
    thr_hi = 8'sd0;
    thr_lo = -8'sd5;
    push_exp(-7, 2'b11, 1'b0);
    send_beat(2, 9, 1'b1, 1'b1);
    @(posedge clk);
    #1;

    // MAX_BEATS beats without in_last: force-closed, 320 reduced.
`ifdef TNN_ACC_SAT_EN
    expected_trunc_sum = 127;
`else
    expected_trunc_sum = 64;
`endif
    thr_hi = 8'sd10;
    thr_lo = -8'sd10;
    push_exp(expected_trunc_sum, 2'b01, 1'b1);
    for (int i = 0; i < MAX_BEATS; i++) begin
      send_beat(20, 0, 1'b0, (i == MAX_BEATS - 1));
    end
    @(posedge clk);
    #1;

    // Back-pressure: result held while a new beat waits.
    out_ready = 1'b0;
    push_exp(3, 2'b00, 1'b0);
    send_beat(4, 1, 1'b1, 1'b1);
    in_valid = 1'b1;
    pc_pos   = 5'd6;
    pc_neg   = 5'd0;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_out_sum", int'(out_sum), 3);
      chk("hold_out_act", int'(out_act), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_exp(6, 2'b00, 1'b0);
    send_beat(6, 0, 1'b1, 1'b1);
    @(posedge clk);
    #1;

    // Reset mid-neuron discards the partial sum.
    thr_hi = 8'sd1;
    thr_lo = -8'sd1;
    send_beat(10, 0, 1'b0, 1'b0);
    send_beat(10, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(0, 2'b00, 1'b0);
    send_beat(1, 1, 1'b1, 1'b1);

    drain = 0;
    while (exp_q.size() != 0 && drain < 50) begin
      drain++;
      @(posedge clk);
    end
    chk("results_outstanding", exp_q.size(), 0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
